// File: rtl/uart_rx_if.sv
// Received-byte channel of the UART receiver: valid/ready byte handshake
// plus the one-cycle error pulses.
interface uart_rx_if #(
  parameter int DATA_BYTE_LENGTH = 8
);
  logic [DATA_BYTE_LENGTH-1:0] data;
  logic                        data_valid;
  logic                        data_ready;
  logic                        frame_err;
  logic                        overrun;

  modport master (output data, data_valid, frame_err, overrun, input data_ready);
  modport slave  (input data, data_valid, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx_byte.sv
// UART receiver: synchronises rx, times bits from the system clock, samples
// mid-bit, assembles LSB-first bytes and hands them out on valid/ready.
module uart_rx_byte #(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD             = 115200,
  parameter int DATA_BYTE_LENGTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [3:0]  state,
  uart_rx_if.master   bus
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam int N          = DATA_BYTE_LENGTH;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_READ  = 4'b0100,
    S_STOP  = 4'b1000
  } state_t;

  state_t          cur, nxt;
  logic            rx_m, rx_s, rx_prev;
  logic [2:0]      vld_pipe;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [N-1:0]    sr, sr_nxt;
  logic            shift_en, stop_smp, byte_done;

  assign state = cur;

  always_comb begin
    nxt      = cur;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    case (cur)
      // vld_pipe[2] marks rx_prev as a real line sample, so the reset value of
      // the synchroniser never fakes a falling edge on a line held low.
      S_IDLE:  if (vld_pipe[2] && !rx_s && rx_prev) nxt = S_START;
      S_START: if (cnt == CW'(HALF - 1)) nxt = rx_s ? S_IDLE : S_READ;
      S_READ:  if (cnt == CW'(BIT_CYCLES - 1)) begin
                 shift_en = 1'b1;
                 if (bit_cnt == 4'(N - 1)) nxt = S_STOP;
               end
      S_STOP:  if (cnt == CW'(BIT_CYCLES - 1)) begin
                 stop_smp = 1'b1;
                 nxt      = S_IDLE;
               end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sr_nxt        = sr >> 1;
    sr_nxt[N-1]   = rx_s;
    byte_done     = stop_smp && rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      rx_prev        <= 1'b1;
      vld_pipe       <= '0;
      cur            <= S_IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_prev  <= rx_s;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      cur      <= nxt;

      // Count restarts on every state entry and after every data-bit sample.
      if (nxt != cur || shift_en)
        cnt <= '0;
      else if (cur == S_START || cur == S_READ || cur == S_STOP)
        cnt <= cnt + 1'b1;

      if (cur == S_START)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= (bit_cnt == 4'(N - 1)) ? 4'd0 : bit_cnt + 4'd1;

      if (shift_en) sr <= sr_nxt;

      bus.frame_err <= stop_smp && !rx_s;
      bus.overrun   <= 1'b0;
      if (byte_done) begin
        if (!bus.data_valid || bus.data_ready) begin
          bus.data       <= sr;
          bus.data_valid <= 1'b1;
        end else begin
          bus.overrun    <= 1'b1;
        end
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frame-level model predicts output events from the
// frame launch time; a negedge process compares every cycle.
module tb_uart_rx_byte;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int N        = 8;
  localparam int BITC     = CLK_FREQ / BAUD;
  localparam int HALF     = BITC / 2;
  // start bit driven just after edge L: 2 sync cycles to the edge detect,
  // first sample HALF+BITC later, N-1 more bits, stop BITC later, +1 register.
  localparam int LAT      = 2 + HALF + BITC + (N - 1) * BITC + BITC + 1;
  localparam int FRAME    = (N + 2) * BITC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] state;

  uart_rx_if #(.DATA_BYTE_LENGTH(N)) bus ();

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BYTE_LENGTH(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .state (state),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           done_at;
    logic [N-1:0] d;
    logic         stop;
  } frame_t;

  frame_t       fq[$];
  logic [N-1:0] got[$];
  int           cyc = 0;
  logic         m_valid = 1'b0;
  logic [N-1:0] m_data  = '0;
  logic         m_fe = 1'b0, m_ov = 1'b0;
  int           fe_cnt = 0, ov_cnt = 0;
  int           n_pass = 0, n_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Model: one output event per launched frame at its completion edge.
  initial forever begin
    frame_t f;
    logic   fin;
    @(posedge clk);
    cyc  = cyc + 1;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      fq.delete();
    end else begin
      fin = 1'b0;
      if (fq.size() > 0 && fq[0].done_at == cyc) begin
        f = fq.pop_front();
        if (f.stop) fin = 1'b1;
        else        m_fe = 1'b1;
      end
      if (fin) begin
        if (!m_valid || bus.data_ready) begin
          m_data  = f.d;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_valid && bus.data_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      check("data_valid", bus.data_valid, m_valid);
      check("data",       bus.data,       m_data);
      check("frame_err",  bus.frame_err,  m_fe);
      check("overrun",    bus.overrun,    m_ov);
      if (bus.data_valid && bus.data_ready) got.push_back(bus.data);
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun)   ov_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] b, input logic stop);
    frame_t f;
    f.done_at = cyc + LAT;
    f.d       = b;
    f.stop    = stop;
    fq.push_back(f);
    rx = 1'b0;
    repeat (BITC) step();
    for (int i = 0; i < N; i++) begin
      rx = b[i];
      repeat (BITC) step();
    end
    rx = stop;
    repeat (BITC) step();
    rx = 1'b1;
  endtask

  initial begin
    logic [N-1:0] part;
    bus.data_ready = 1'b0;
    rx = 1'b0;
    step();
    check("rst_data",  bus.data,       0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_fe",    bus.frame_err,  0);
    check("rst_ov",    bus.overrun,    0);
    check("rst_state", state,          4'b0001);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("low_from_reset_idle", state, 4'b0001);
    rx = 1'b1;
    repeat (5) step();

    // 1: single byte held, then consumed
    send_frame(8'hA5, 1'b1);
    check("s1_data",  bus.data,       8'hA5);
    check("s1_valid", bus.data_valid, 1);
    repeat (3) step();
    check("s1_held",  bus.data_valid, 1);
    bus.data_ready = 1'b1;
    step();
    bus.data_ready = 1'b0;
    check("s1_consumed", bus.data_valid, 0);

    // 2: back-to-back with ready tied high
    got.delete();
    bus.data_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (3) step();
    bus.data_ready = 1'b0;
    check("s2_count", got.size(), 2);
    check("s2_byte0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 8'h00);
    check("s2_byte1", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF, 8'hFF);
    check("s2_no_fe", fe_cnt, 0);
    check("s2_no_ov", ov_cnt, 0);

    // 3: framing error
    send_frame(8'h3C, 1'b0);
    repeat (3) step();
    check("s3_fe_once", fe_cnt,         1);
    check("s3_valid",   bus.data_valid, 0);
    check("s3_state",   state,          4'b0001);

    // 4: short glitch
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    check("s4_start", state, 4'b0010);
    repeat (6) step();
    check("s4_idle",  state,          4'b0001);
    check("s4_valid", bus.data_valid, 0);

    // 5a: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) step();
    check("s5_data",  bus.data,       8'h11);
    check("s5_valid", bus.data_valid, 1);
    check("s5_ov",    ov_cnt,         1);
    bus.data_ready = 1'b1;
    step();
    bus.data_ready = 1'b0;

    // 5b: ready exactly in the completion cycle of the second byte
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        repeat (FRAME + LAT - 1) step();
        bus.data_ready = 1'b1;
        step();
        bus.data_ready = 1'b0;
      end
    join
    repeat (2) step();
    check("s5b_data",  bus.data,       8'h22);
    check("s5b_valid", bus.data_valid, 1);
    check("s5b_no_ov", ov_cnt,         1);

    // 6: reset after bit 4, then a clean frame
    part = 8'h96;
    rx = 1'b0;
    repeat (BITC) step();
    for (int i = 0; i < 5; i++) begin
      rx = part[i];
      repeat (BITC) step();
    end
    rst = 1'b1;
    rx  = 1'b1;
    step();
    rst = 1'b0;
    check("s6_state", state,          4'b0001);
    check("s6_valid", bus.data_valid, 0);
    check("s6_data",  bus.data,       0);
    repeat (5) step();
    send_frame(8'h5A, 1'b1);
    repeat (3) step();
    check("s6_rx_data",  bus.data,       8'h5A);
    check("s6_rx_valid", bus.data_valid, 1);
    check("fe_total",    fe_cnt,         1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Complete UART receive stage that feeds the byte-level consumers. It sits between the raw rx pin and the byte FIFO/command parser.
- Synchronises the asynchronous rx line and times each bit from the system clock, with no external baud tick.
- Samples each bit at mid-bit, assembles LSB-first data and checks the stop bit.
- Presents each received byte on a valid/ready interface and flags framing and overrun errors.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line bit rate. BIT_CYCLES = CLK_FREQ/BAUD (integer divide), HALF = BIT_CYCLES/2. Constraint: BIT_CYCLES >= 4.
DATA_BYTE_LENGTH, 8, data bits per frame (1..8). No parity; one stop bit.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BYTE_LENGTH  received byte, LSB = first bit on the line
data_valid  output  1  data holds an unconsumed byte
data_ready  input  1  consumer accepts data when data_valid && data_ready at a clock edge
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while the previous byte was still unconsumed
state  output  4  one-hot FSM state for debug: IDLE=4'b0001, START=4'b0010, READING=4'b0100, STOP=4'b1000

Behaviour:
- Reset values: data=0, data_valid=0, frame_err=0, overrun=0, state=IDLE, bit counter=0, cycle counter=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser; rx_s denotes its output. No other logic reads rx directly.
- Cycle counter: cleared on every state entry; increments every clock while in START, READING or STOP.
- IDLE:
  - Transition to START when rx_s==0 and its previous registered value was 1 (falling edge). A line held low from reset does not start a frame.
- START:
  - At cycle count HALF-1, sample rx_s.
  - If rx_s is 0, go to READING with bit counter=0.
  - If rx_s is 1, treat as a glitch: return to IDLE with no flags.
- READING:
  - At cycle count BIT_CYCLES-1, shift rx_s into the shift register (LSB first) and restart the cycle count.
  - After bit DATA_BYTE_LENGTH-1 is sampled, clear the bit counter and go to STOP.
- STOP:
  - At cycle count BIT_CYCLES-1, sample rx_s and go to IDLE.
  - Sample high: byte completes (see output rules).
  - Sample low: frame_err pulses for 1 cycle, byte is discarded, data and data_valid are unchanged.
  - The return to IDLE occurs at mid-stop-bit, so back-to-back frames are received with no extra idle time.
- Output register rules when a byte completes (cycle C, registered outputs update at C+1):
  - data_valid==0: data is loaded and data_valid=1.
  - data_valid==1 and data_ready==1 in the same cycle: old byte is consumed, new byte is loaded, data_valid stays 1, no overrun.
  - data_valid==1 and data_ready==0: new byte is dropped, the old byte is kept, overrun pulses for 1 cycle.
- Handshake: on data_valid && data_ready with no byte completing, data_valid clears next cycle. data stays stable while data_valid==1 and there is no handshake. data_ready is ignored while data_valid==0.
- Latency: first data sample is HALF+BIT_CYCLES cycles after IDLE detects the edge. data_valid rises 1 cycle after the stop sample.
- Reset asserted mid-frame: every register returns to its reset value on the next edge. The partial byte is lost and no flags are raised.
- Any non-one-hot state value: return to IDLE on the next clock.

Test Plan:
For all scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (BIT_CYCLES=10, HALF=5) and 8 data bits.
1. Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop), data_ready=0 -> data=8'hA5, data_valid=1 held. Then data_ready=1 for one cycle -> data_valid=0 next cycle. No flags.
2. Back-to-back 0x00 then 0xFF with no idle gap, data_ready tied 1 -> two data_valid events carrying 8'h00 then 8'hFF. frame_err=0, overrun=0.
3. Frame 0x3C with stop bit driven low -> frame_err pulses exactly 1 cycle, data_valid stays 0, state returns to IDLE.
4. rx low pulse of 3 cycles (shorter than HALF) -> state goes START then IDLE, no data_valid, no flags.
5. Two frames 0x11 then 0x22, data_ready=0 throughout -> data=8'h11 retained and overrun pulses once. Repeat with data_ready=1 in the exact completion cycle of 0x22 -> data=8'h22, data_valid=1, overrun=0.
6. rst asserted for 1 cycle after bit 4 of a frame -> state=IDLE, data_valid=0 next cycle. A following full frame 0x5A is received correctly.
